regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Sole driver of the GPR file write channel (write_en/write_addr/write_data).
//  Merges two writeback sources: the in-order pipeline WB stage (always wins) and a
//  long-latency unit (mult/div, load-miss return) that is buffered in a small FIFO.
//  Buffered results drain in order on cycles with no pipeline write. Decode queries
//  pending destinations here to stall RAW consumers.
// PARAMETERS
//  DEPTH       4   FIFO entries for long-latency results; power of 2, >= 2
//  ADDR_WIDTH  5   GPR index width
//  DATA_WIDTH  32  GPR data width
// PORTS
//  clk           in   1           rising-edge clock
//  rst_n         in   1           asynchronous, active-low reset
//  pipe_valid    in   1           WB stage has a result this cycle (never back-pressured)
//  pipe_addr     in   ADDR_WIDTH  WB destination register
//  pipe_data     in   DATA_WIDTH  WB result
//  lu_valid      in   1           long-latency result offered
//  lu_ready      out  1           FIFO can accept; transfer on lu_valid && lu_ready
//  lu_addr       in   ADDR_WIDTH  long-latency destination register
//  lu_data       in   DATA_WIDTH  long-latency result
//  query_addr_1  in   ADDR_WIDTH  decode source operand 1
//  query_hit_1   out  1           query_addr_1 has a live pending FIFO entry
//  query_addr_2  in   ADDR_WIDTH  decode source operand 2
//  query_hit_2   out  1           query_addr_2 has a live pending FIFO entry
//  write_en      out  1           to register file write channel (registered)
//  write_addr    out  ADDR_WIDTH  registered
//  write_data    out  DATA_WIDTH  registered
// BEHAVIOUR
//  - Reset (async, rst_n=0): write_en/addr/data=0, FIFO empty, all entry-live bits 0,
//    lu_ready=1, query_hit_*=0. Reset mid-drain discards all buffered entries.
//  - Writes to register 0 from either source are dropped at input: never enqueued,
//    never issued. write_en is never asserted with write_addr==0.
//  - Output register loaded every cycle; latency pipe -> write_* = 1 cycle.
//  - Select each cycle: pipe_valid (addr!=0) -> issue pipe; else head entry live ->
//    issue and pop head; else head present but killed -> pop, write_en=0 next cycle;
//    else write_en=0 (addr/data hold their previous values).
//  - Enqueue on lu_valid && lu_ready (addr!=0): tail gets {live=1,addr,data}; min
//    latency lu -> write_* = 2 cycles (no bypass).
//  - lu_ready = (count < DEPTH), from registered count only; a pop in the same cycle
//    does not open a slot when full. Enqueue and pop in one cycle: count unchanged.
//  - WAW kill: a pipeline write to addr X clears live on every FIFO entry with addr X
//    (same edge). An entry enqueued in the same cycle as a pipe write to X is
//    younger and is NOT killed.
//  - query_hit_n = OR over stored entries of (live && addr==query_addr_n), combinational;
//    query_addr_n==0 -> 0. The value in the output register is not reported (the
//    register file forwards it).
//  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
// TESTING
//  1. pipe r5=0xDEADBEEF one cycle -> next cycle write_en=1, addr=5, data=0xDEADBEEF, then 0.
//  2. pipe_valid=1 addr 0, and lu push r0 -> write_en stays 0; count stays 0; lu_ready=1.
//  3. pipe busy 8 cycles (r10..r17); lu pushes r1..r5 -> lu_ready=0 after 4th accept;
//     r1..r4 issued back-to-back after pipe idles, then r5, in order.
//  4. lu push r7=0x11; next cycle pipe r7=0x22 -> only 0x22 written to r7;
//     query_hit_1 (addr 7) 1 then 0; killed entry popped with no write.
//  5. Same cycle: pipe r9=0xA and lu push r9=0xB -> writes 0xA then 0xB (younger kept).
//  6. FIFO full with 4 entries, drive rst_n=0 mid-drain -> write_en=0 immediately,
//     lu_ready=1, query_hit_*=0; no buffered write appears after release.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback sources, decode queries and GPR write channel
//
// Purpose: bundles every non-clock signal of regfile_write_arbiter.
// Ports (signals):
//   pipe_valid/pipe_addr/pipe_data   WB stage result, never back-pressured
//   lu_valid/lu_ready/lu_addr/lu_data long-latency result handshake
//   query_addr_1/2, query_hit_1/2    decode RAW lookup of pending results
//   write_en/write_addr/write_data   registered GPR file write channel
// Modports: slave = arbiter side, master = pipeline/decode/regfile side.
interface regfile_write_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  pipe_valid;
  logic [ADDR_WIDTH-1:0] pipe_addr;
  logic [DATA_WIDTH-1:0] pipe_data;

  logic                  lu_valid;
  logic                  lu_ready;
  logic [ADDR_WIDTH-1:0] lu_addr;
  logic [DATA_WIDTH-1:0] lu_data;

  logic [ADDR_WIDTH-1:0] query_addr_1;
  logic                  query_hit_1;
  logic [ADDR_WIDTH-1:0] query_addr_2;
  logic                  query_hit_2;

  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;

  modport slave (
    input  pipe_valid, pipe_addr, pipe_data,
    input  lu_valid, lu_addr, lu_data,
    output lu_ready,
    input  query_addr_1, query_addr_2,
    output query_hit_1, query_hit_2,
    output write_en, write_addr, write_data
  );

  modport master (
    output pipe_valid, pipe_addr, pipe_data,
    output lu_valid, lu_addr, lu_data,
    input  lu_ready,
    output query_addr_1, query_addr_2,
    input  query_hit_1, query_hit_2,
    input  write_en, write_addr, write_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - GPR write-channel arbiter with long-latency result FIFO
//
// Purpose: sole driver of the register file write channel. The pipeline WB stage
//   always wins; long-latency results wait in a DEPTH-entry FIFO and drain in order
//   on cycles without a pipeline write. A pipeline write kills older buffered
//   results to the same register (WAW). Decode asks whether a register still has a
//   live buffered result so it can stall RAW consumers.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    regfile_write_arbiter_if.slave (pipe_*, lu_*, query_*, write_*)
// Parameters: DEPTH (power of 2, >= 2), ADDR_WIDTH, DATA_WIDTH.
module regfile_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  regfile_write_arbiter_if.slave       bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO state
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [DEPTH-1:0]      live_q;
  logic [DEPTH-1:0]      live_next;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  // Output register
  logic                  write_en_q;
  logic [ADDR_WIDTH-1:0] write_addr_q;
  logic [DATA_WIDTH-1:0] write_data_q;

  logic pipe_take;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic issue_lu;
  logic hit_1;
  logic hit_2;

  // Register 0 is hardwired; writes to it are discarded before arbitration.
  assign pipe_take  = bus.pipe_valid && (bus.pipe_addr != '0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));

  // Ready comes only from the registered count: a pop this cycle does not
  // free a slot for an enqueue in the same cycle.
  assign push     = bus.lu_valid && !fifo_full && (bus.lu_addr != '0);

  // Head leaves whenever the pipe is idle; a killed head is simply dropped.
  assign pop      = !pipe_take && !fifo_empty;
  assign issue_lu = pop && live_q[rd_ptr];

  // Live bits: kill, then pop, then push. Slots outside the occupied range
  // are always kept at 0 so the query OR can scan every slot. The push slot
  // is never the popped slot (empty blocks pop, full blocks push), and the
  // kill compares only already-stored addresses, so a same-cycle enqueue to
  // the pipe's destination stays live.
  always_comb begin
    live_next = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_take && (addr_mem[i] == bus.pipe_addr)) begin
        live_next[i] = 1'b0;
      end
    end
    if (pop) begin
      live_next[rd_ptr] = 1'b0;
    end
    if (push) begin
      live_next[wr_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      live_q <= '0;
    end else begin
      live_q <= live_next;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: validity is carried entirely by live_q/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.lu_addr;
      data_mem[wr_ptr] <= bus.lu_data;
    end
  end

  // Write channel register. addr/data hold on idle cycles to avoid needless toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      write_en_q <= pipe_take || issue_lu;
      if (pipe_take) begin
        write_addr_q <= bus.pipe_addr;
        write_data_q <= bus.pipe_data;
      end else if (issue_lu) begin
        write_addr_q <= addr_mem[rd_ptr];
        write_data_q <= data_mem[rd_ptr];
      end
    end
  end

  // Pending-destination lookup over buffered entries only; the value sitting in
  // the output register is forwarded by the register file itself.
  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_mem[i] == bus.query_addr_1)) begin
        hit_1 = 1'b1;
      end
      if (live_q[i] && (addr_mem[i] == bus.query_addr_2)) begin
        hit_2 = 1'b1;
      end
    end
    if (bus.query_addr_1 == '0) begin
      hit_1 = 1'b0;
    end
    if (bus.query_addr_2 == '0) begin
      hit_2 = 1'b0;
    end
  end

  assign bus.lu_ready    = !fifo_full;
  assign bus.query_hit_1 = hit_1;
  assign bus.query_hit_2 = hit_2;
  assign bus.write_en    = write_en_q;
  assign bus.write_addr  = write_addr_q;
  assign bus.write_data  = write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic rst_n;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(.DEPTH(DEPTH), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;
  ent_t mq[$];
  ent_t exp_q[$];
  ent_t mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_hit(input logic [4:0] q);
    bit h = 0;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].live && mq[i].addr == q && q != 5'd0) h = 1;
    end
    return h;
  endfunction

  // Drives one cycle of stimulus at the falling edge and advances the reference queue.
  task automatic step(input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic [4:0] q1, input logic [4:0] q2);
    bit   ready_m;
    ent_t t;
    @(negedge clk);
    bus.pipe_valid   = pv;
    bus.pipe_addr    = pa;
    bus.pipe_data    = pd;
    bus.lu_valid     = lv;
    bus.lu_addr      = la;
    bus.lu_data      = ld;
    bus.query_addr_1 = q1;
    bus.query_addr_2 = q2;
    ready_m = (mq.size() < DEPTH);
    if (pv && pa != 5'd0) begin
      exp_q.push_back({1'b1, pa, pd});
      for (int i = 0; i < mq.size(); i++) begin
        t = mq[i];
        if (t.addr == pa) begin
          t.live = 1'b0;
          mq[i] = t;
        end
      end
    end else if (mq.size() > 0) begin
      t = mq.pop_front();
      if (t.live) exp_q.push_back(t);
    end
    if (lv && ready_m && la != 5'd0) mq.push_back({1'b1, la, ld});
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Scoreboard monitor: every write must match the oldest expected write.
  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (bus.write_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%h, none expected",
                   bus.write_addr, bus.write_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.write_addr !== mon_e.addr || bus.write_data !== mon_e.data) begin
            errors++;
            $display("FAIL write_order: got addr=%0d data=%h, want addr=%0d data=%h",
                     bus.write_addr, bus.write_data, mon_e.addr, mon_e.data);
          end
        end
      end
      checks++;
      if (bus.lu_ready !== (mq.size() < DEPTH)) begin
        errors++;
        $display("FAIL lu_ready: got %b want %b", bus.lu_ready, mq.size() < DEPTH);
      end
      checks++;
      if (bus.query_hit_1 !== model_hit(bus.query_addr_1)) begin
        errors++;
        $display("FAIL query_hit_1: addr=%0d got %b want %b", bus.query_addr_1,
                 bus.query_hit_1, model_hit(bus.query_addr_1));
      end
      checks++;
      if (bus.query_hit_2 !== model_hit(bus.query_addr_2)) begin
        errors++;
        $display("FAIL query_hit_2: addr=%0d got %b want %b", bus.query_addr_2,
                 bus.query_hit_2, model_hit(bus.query_addr_2));
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    bus.pipe_valid = 0; bus.pipe_addr = 0; bus.pipe_data = 0;
    bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0;
    bus.query_addr_1 = 0; bus.query_addr_2 = 0;
    #12;
    checks++;
    if (bus.write_en !== 1'b0 || bus.write_addr !== 5'd0 || bus.write_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_write: got en=%b addr=%0d data=%h want 0/0/0",
               bus.write_en, bus.write_addr, bus.write_data);
    end
    checks++;
    if (bus.lu_ready !== 1'b1 || bus.query_hit_1 !== 1'b0 || bus.query_hit_2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got ready=%b hit1=%b hit2=%b want 1/0/0",
               bus.lu_ready, bus.query_hit_1, bus.query_hit_2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;
  endtask

  task automatic test_pipe_single;
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (bus.write_en !== 1'b1 || bus.write_addr !== 5'd5 || bus.write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL pipe_latency: got en=%b addr=%0d data=%h want 1/5/deadbeef",
               bus.write_en, bus.write_addr, bus.write_data);
    end
    idle(1);
    #1;
    checks++;
    if (bus.write_en !== 1'b0) begin
      errors++;
      $display("FAIL pipe_single_off: got en=%b want 0", bus.write_en);
    end
  endtask

  task automatic test_reg0_drop;
    step(1, 5'd0, 32'h1234, 1, 5'd0, 32'h5678, 5'd0, 5'd0);
    #1;
    checks++;
    if (bus.write_en !== 1'b0 || bus.lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reg0_drop: got en=%b ready=%b want 0/1", bus.write_en, bus.lu_ready);
    end
    idle(2);
    #1;
    checks++;
    if (bus.write_en !== 1'b0 || mq.size() != 0) begin
      errors++;
      $display("FAIL reg0_drain: got en=%b model_count=%0d want 0/0", bus.write_en, mq.size());
    end
  endtask

  task automatic test_back_to_back;
    int  lu_idx = 0;
    bit  rdy;
    bit  lv;
    for (int k = 0; k < 13; k++) begin
      rdy = bus.lu_ready;
      lv  = (lu_idx < 5);
      step(k < 8, 5'(10 + k), 32'h100 + 32'(k), lv, 5'(1 + lu_idx), 32'h200 + 32'(lu_idx),
           5'd3, 5'd5);
      if (rdy && lv) lu_idx++;
      #1;
      if (k == 3) begin
        checks++;
        if (bus.lu_ready !== 1'b0) begin
          errors++;
          $display("FAIL full_ready: got %b want 0 after 4 accepts", bus.lu_ready);
        end
      end
      if (k >= 8) begin
        checks++;
        if (bus.write_en !== 1'b1) begin
          errors++;
          $display("FAIL drain_b2b: cycle %0d got en=%b want 1", k, bus.write_en);
        end
      end
    end
    idle(1);
    #1;
    checks++;
    if (bus.write_en !== 1'b0 || exp_q.size() != 0 || lu_idx != 5) begin
      errors++;
      $display("FAIL drain_done: got en=%b pending=%0d accepted=%0d want 0/0/5",
               bus.write_en, exp_q.size(), lu_idx);
    end
  endtask

  task automatic test_waw_kill;
    step(0, 0, 0, 1, 5'd7, 32'h11, 5'd7, 5'd0);
    #1;
    checks++;
    if (bus.query_hit_1 !== 1'b1) begin
      errors++;
      $display("FAIL waw_hit_before: got %b want 1", bus.query_hit_1);
    end
    step(1, 5'd7, 32'h22, 0, 0, 0, 5'd7, 5'd0);
    #1;
    checks++;
    if (bus.query_hit_1 !== 1'b0 || bus.write_data !== 32'h22) begin
      errors++;
      $display("FAIL waw_kill: got hit=%b data=%h want 0/22", bus.query_hit_1, bus.write_data);
    end
    step(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
    #1;
    checks++;
    if (bus.write_en !== 1'b0) begin
      errors++;
      $display("FAIL waw_killed_pop: got en=%b want 0", bus.write_en);
    end
    idle(2);
  endtask

  task automatic test_same_cycle_younger;
    step(1, 5'd9, 32'hA, 1, 5'd9, 32'hB, 5'd9, 5'd9);
    #1;
    checks++;
    if (bus.write_data !== 32'hA || bus.query_hit_1 !== 1'b1) begin
      errors++;
      $display("FAIL younger_first: got data=%h hit=%b want a/1", bus.write_data, bus.query_hit_1);
    end
    step(0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
    #1;
    checks++;
    if (bus.write_en !== 1'b1 || bus.write_addr !== 5'd9 || bus.write_data !== 32'hB) begin
      errors++;
      $display("FAIL younger_kept: got en=%b addr=%0d data=%h want 1/9/b",
               bus.write_en, bus.write_addr, bus.write_data);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_drain;
    int stray = 0;
    for (int k = 0; k < 4; k++) begin
      step(1, 5'(20 + k), 32'h300 + 32'(k), 1, 5'(1 + k), 32'h400 + 32'(k), 5'd3, 5'd4);
    end
    step(0, 0, 0, 0, 0, 0, 5'd3, 5'd4);
    @(negedge clk);
    #2;
    mon_en = 0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (bus.write_en !== 1'b0 || bus.lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_write: got en=%b ready=%b want 0/1", bus.write_en, bus.lu_ready);
    end
    checks++;
    if (bus.query_hit_1 !== 1'b0 || bus.query_hit_2 !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_query: got hit1=%b hit2=%b want 0/0",
               bus.query_hit_1, bus.query_hit_2);
    end
    mq.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1;
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, 0, 0, 5'd3, 5'd4);
      #1;
      if (bus.write_en === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_discard: got %0d stray writes want 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_pipe_single();
    test_reg0_drop();
    test_back_to_back();
    test_waw_kill();
    test_same_cycle_younger();
    test_reset_mid_drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
